// File: rtl/demux1to2_reg_if.sv
// Bundle of the demux's input stream, its two output streams and the per-port counters.
// The producer/consumer side uses master and the demux itself uses slave.
interface demux1to2_reg_if #(
  parameter int WIDTH = 16,
  parameter int CNTW  = 8
);
  logic             E;
  logic             S;
  logic [WIDTH-1:0] X;
  logic             X_valid;
  logic             X_ready;
  logic [WIDTH-1:0] Z0;
  logic             Z0_valid;
  logic             Z0_ready;
  logic [WIDTH-1:0] Z1;
  logic             Z1_valid;
  logic             Z1_ready;
  logic [CNTW-1:0]  cnt0;
  logic [CNTW-1:0]  cnt1;

  modport master (
    output E, S, X, X_valid, Z0_ready, Z1_ready,
    input  X_ready, Z0, Z0_valid, Z1, Z1_valid, cnt0, cnt1
  );

  modport slave (
    input  E, S, X, X_valid, Z0_ready, Z1_ready,
    output X_ready, Z0, Z0_valid, Z1, Z1_valid, cnt0, cnt1
  );
endinterface

// File: rtl/demux1to2_reg.sv
// Registered 1-to-2 demux: S=1 steers X into port 0 and S=0 steers it into port 1.
// Each port has a single-entry skid-free slot and a saturating count of the words it has delivered.
module demux1to2_slot #(
  parameter int WIDTH = 16,
  parameter int CNTW  = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_ready,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_data,
  output logic [CNTW-1:0]  o_cnt,
  output logic             o_can_load
);
  logic             r_valid;
  logic [WIDTH-1:0] r_data;
  logic [CNTW-1:0]  r_cnt;
  logic             w_drain;

  assign w_drain    = r_valid & i_ready;
  // A full slot can take a new word in the same cycle it drains, so there is no bubble.
  assign o_can_load = ~r_valid | i_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_cnt   <= '0;
    end else begin
      if (i_load) begin
        r_valid <= 1'b1;
        r_data  <= i_data;
      end else if (w_drain) begin
        r_valid <= 1'b0;
      end
      if (w_drain && (r_cnt != {CNTW{1'b1}}))
        r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;
  assign o_cnt   = r_cnt;
endmodule

module demux1to2_reg #(
  parameter int WIDTH = 16,
  parameter int CNTW  = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  demux1to2_reg_if.slave   bus
);
  localparam int NUM_PORTS = 2;

  logic [NUM_PORTS-1:0]            w_ready;
  logic [NUM_PORTS-1:0]            w_load;
  logic [NUM_PORTS-1:0]            w_valid;
  logic [NUM_PORTS-1:0]            w_can_load;
  logic [NUM_PORTS-1:0][WIDTH-1:0] w_z;
  logic [NUM_PORTS-1:0][CNTW-1:0]  w_cnt;
  logic                            w_accept;

  assign w_ready     = {bus.Z1_ready, bus.Z0_ready};
  assign bus.X_ready = bus.E & rst_n & (bus.S ? w_can_load[0] : w_can_load[1]);
  assign w_accept    = bus.X_valid & bus.X_ready;
  assign w_load      = {w_accept & ~bus.S, w_accept & bus.S};

  for (genvar k = 0; k < NUM_PORTS; k++) begin : g_port
    demux1to2_slot #(.WIDTH(WIDTH), .CNTW(CNTW)) u_slot (
      .clk        (clk),
      .rst_n      (rst_n),
      .i_load     (w_load[k]),
      .i_data     (bus.X),
      .i_ready    (w_ready[k]),
      .o_valid    (w_valid[k]),
      .o_data     (w_z[k]),
      .o_cnt      (w_cnt[k]),
      .o_can_load (w_can_load[k])
    );
  end

  assign bus.Z0       = w_z[0];
  assign bus.Z0_valid = w_valid[0];
  assign bus.cnt0     = w_cnt[0];
  assign bus.Z1       = w_z[1];
  assign bus.Z1_valid = w_valid[1];
  assign bus.cnt1     = w_cnt[1];
endmodule

// File: tb/tb_demux1to2_reg.sv
// Bench for demux1to2_reg: directed scenarios with literal expectations, then random traffic
// checked every cycle against a queue-based model of the two output slots.
module tb_demux1to2_reg;
  localparam int W  = 16;
  localparam int CW = 8;
  localparam int CMAX = (1 << CW) - 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;
  bit   chk_en = 1'b0;

  demux1to2_reg_if #(.WIDTH(W), .CNTW(CW)) bus ();

  demux1to2_reg #(.WIDTH(W), .CNTW(CW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Model: each port is a queue holding at most one word; lastk is what Zk must show.
  logic [W-1:0] q0[$];
  logic [W-1:0] q1[$];
  logic [W-1:0] last0 = '0;
  logic [W-1:0] last1 = '0;
  int           c0 = 0;
  int           c1 = 0;

  function automatic logic model_ready();
    logic room0, room1;
    room0 = (q0.size() == 0) || bus.Z0_ready;
    room1 = (q1.size() == 0) || bus.Z1_ready;
    return bus.E && rst_n && (bus.S ? room0 : room1);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q0.delete();
      q1.delete();
      last0 = '0;
      last1 = '0;
      c0 = 0;
      c1 = 0;
    end else begin
      logic acc;
      acc = bus.X_valid && model_ready();
      if (q0.size() != 0 && bus.Z0_ready) begin
        void'(q0.pop_front());
        c0 = (c0 < CMAX) ? c0 + 1 : CMAX;
      end
      if (q1.size() != 0 && bus.Z1_ready) begin
        void'(q1.pop_front());
        c1 = (c1 < CMAX) ? c1 + 1 : CMAX;
      end
      if (acc && bus.S) begin
        q0.push_back(bus.X);
        last0 = bus.X;
      end
      if (acc && !bus.S) begin
        q1.push_back(bus.X);
        last1 = bus.X;
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Every negedge the DUT must agree with the model.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("x_ready", 32'(bus.X_ready), 32'(model_ready()));
      chk("z0_valid", 32'(bus.Z0_valid), 32'(q0.size() != 0));
      chk("z1_valid", 32'(bus.Z1_valid), 32'(q1.size() != 0));
      chk("z0", 32'(bus.Z0), 32'(last0));
      chk("z1", 32'(bus.Z1), 32'(last1));
      chk("cnt0", 32'(bus.cnt0), 32'(c0));
      chk("cnt1", 32'(bus.cnt1), 32'(c1));
    end
  end

  task automatic cyc();
    @(negedge clk);
    #1;
  endtask

  initial begin
    bus.E = 1'b0; bus.S = 1'b0; bus.X = '0; bus.X_valid = 1'b0;
    bus.Z0_ready = 1'b0; bus.Z1_ready = 1'b0;
    repeat (2) cyc();
    chk("rst_x_ready", 32'(bus.X_ready), 32'd0);
    chk("rst_cnt0", 32'(bus.cnt0), 32'd0);
    rst_n = 1'b1;
    chk_en = 1'b1;
    cyc();

    // single word through port 0
    bus.E = 1'b1; bus.S = 1'b1; bus.X = 16'hA5A5; bus.X_valid = 1'b1; bus.Z0_ready = 1'b1;
    cyc();
    bus.X_valid = 1'b0;
    chk("t1_z0_valid", 32'(bus.Z0_valid), 32'd1);
    chk("t1_z0", 32'(bus.Z0), 32'hA5A5);
    chk("t1_z1_valid", 32'(bus.Z1_valid), 32'd0);
    cyc();
    chk("t1_z0_drained", 32'(bus.Z0_valid), 32'd0);
    chk("t1_cnt0", 32'(bus.cnt0), 32'd1);

    // back-to-back stream on port 1
    bus.S = 1'b0; bus.Z1_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      bus.X = 16'(i); bus.X_valid = 1'b1;
      #1 chk("t2_x_ready", 32'(bus.X_ready), 32'd1);
      cyc();
      chk("t2_z1", 32'(bus.Z1), 32'(i));
      chk("t2_z1_valid", 32'(bus.Z1_valid), 32'd1);
    end
    bus.X_valid = 1'b0;
    cyc();
    chk("t2_cnt1", 32'(bus.cnt1), 32'd4);

    // stalled port 0 blocks only while selected
    bus.S = 1'b1; bus.Z0_ready = 1'b0; bus.X = 16'h1111; bus.X_valid = 1'b1;
    cyc();
    bus.X = 16'h2222;
    #1 chk("t3_blocked", 32'(bus.X_ready), 32'd0);
    cyc();
    chk("t3_z0_hold", 32'(bus.Z0), 32'h1111);
    chk("t3_z0_valid", 32'(bus.Z0_valid), 32'd1);
    bus.S = 1'b0;
    #1 chk("t3_switch_ready", 32'(bus.X_ready), 32'd1);
    cyc();
    chk("t3_z1", 32'(bus.Z1), 32'h2222);

    // enable low: no accept, but port 1 still drains and counts
    bus.E = 1'b0; bus.X = 16'h3333;
    #1 chk("t4_ready_e0", 32'(bus.X_ready), 32'd0);
    cyc();
    chk("t4_z1_valid", 32'(bus.Z1_valid), 32'd0);
    chk("t4_z1_keep", 32'(bus.Z1), 32'h2222);
    chk("t4_cnt1", 32'(bus.cnt1), 32'd5);

    // asynchronous reset with both ports full
    bus.E = 1'b1; bus.Z1_ready = 1'b0; bus.X = 16'h4444;
    cyc();
    bus.X_valid = 1'b0;
    chk("t5_both_full", 32'({bus.Z1_valid, bus.Z0_valid}), 32'd3);
    rst_n = 1'b0;
    #1;
    chk("t5_valid", 32'({bus.Z1_valid, bus.Z0_valid}), 32'd0);
    chk("t5_z", 32'({bus.Z1, bus.Z0}), 32'd0);
    chk("t5_cnt", 32'({bus.cnt1, bus.cnt0}), 32'd0);
    cyc();
    rst_n = 1'b1;
    cyc();

    // saturation on port 0
    bus.S = 1'b1; bus.Z0_ready = 1'b1; bus.X_valid = 1'b1;
    for (int i = 0; i < 260; i++) begin
      bus.X = 16'($urandom);
      cyc();
    end
    bus.X_valid = 1'b0;
    cyc();
    chk("t6_sat", 32'(bus.cnt0), 32'd255);
    repeat (3) cyc();
    chk("t6_sat_hold", 32'(bus.cnt0), 32'd255);

    // random traffic against the model
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      bus.E        = ($urandom_range(0, 7) != 0);
      bus.S        = 1'($urandom);
      bus.X        = 16'($urandom);
      bus.X_valid  = ($urandom_range(0, 9) < 7);
      bus.Z0_ready = ($urandom_range(0, 3) != 0);
      bus.Z1_ready = ($urandom_range(0, 3) != 0);
      cyc();
    end
    bus.X_valid = 1'b0;
    cyc();
    chk_en = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
